// File: rtl/branch1_sequencer.sv
// Branch-1 pass controller: walks the sample memories 0..len-1, forwards a
// data-aligned valid/address to the calc stage and waits for every completion.
module branch1_sequencer #(
    parameter int BRANCH_SIZE = 3072,
    parameter int AW          = $clog2(BRANCH_SIZE),
    parameter int MEM_LAT     = 1,
    parameter int CALC_LAT    = 2
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          i_start,
    input  logic [AW:0]   i_len,
    input  logic          i_pause,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_mem_en,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_calc_valid,
    output logic [AW-1:0] o_calc_addr,
    input  logic          i_calc_valid,
    output logic          o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [AW:0] MAX_LEN = (AW+1)'(BRANCH_SIZE);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_e        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   issue_q, issue_d;
    logic [AW:0]   cmpl_q, cmpl_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cv_q [MEM_LAT];
    logic [AW-1:0] ca_q [MEM_LAT];

    logic          mem_en_s;
    logic [AW-1:0] mem_addr_s;
    logic [AW:0]   len_clamp_s;
    logic          cmpl_ok_s;

    // Issue strobe follows i_pause in the same cycle so a paused cycle never reads.
    assign mem_en_s    = (state_q == S_ISSUE) && !i_pause;
    assign mem_addr_s  = mem_en_s ? issue_q[AW-1:0] : {AW{1'b0}};
    assign len_clamp_s = (i_len > MAX_LEN) ? MAX_LEN : i_len;
    assign cmpl_ok_s   = i_calc_valid && (cmpl_q < issue_q);

    // Next-state logic for the pass FSM, counters and status flags.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        issue_d = issue_q;
        cmpl_d  = cmpl_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (cmpl_ok_s) begin
            cmpl_d = cmpl_q + ONE;
        end else if (i_calc_valid) begin
            err_d = 1'b1;
        end else begin
            cmpl_d = cmpl_q;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    len_d   = len_clamp_s;
                    issue_d = {(AW+1){1'b0}};
                    cmpl_d  = {(AW+1){1'b0}};
                    err_d   = 1'b0;
                    if (len_clamp_s == {(AW+1){1'b0}}) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_ISSUE;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (mem_en_s) begin
                    issue_d = issue_q + ONE;
                    if (issue_q == len_q - ONE) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    issue_d = issue_q;
                end
            end
            S_DRAIN: begin
                // The final completion and the move to DONE share one edge.
                if (cmpl_d == len_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters, flags and the memory-latency alignment line.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            len_q   <= {(AW+1){1'b0}};
            issue_q <= {(AW+1){1'b0}};
            cmpl_q  <= {(AW+1){1'b0}};
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < MEM_LAT; i++) begin
                cv_q[i] <= 1'b0;
                ca_q[i] <= {AW{1'b0}};
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            issue_q <= issue_d;
            cmpl_q  <= cmpl_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cv_q[0] <= mem_en_s;
            ca_q[0] <= mem_addr_s;
            for (int i = 1; i < MEM_LAT; i++) begin
                cv_q[i] <= cv_q[i-1];
                ca_q[i] <= ca_q[i-1];
            end
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_mem_en     = mem_en_s;
    assign o_mem_addr   = mem_addr_s;
    assign o_calc_valid = cv_q[MEM_LAT-1];
    assign o_calc_addr  = ca_q[MEM_LAT-1];

endmodule

// File: tb/tb_branch1_sequencer.sv
// Bench for branch1_sequencer: per-pass timeline model built from the pass
// rules, a 2-cycle calc stage, directed corner cases and randomized passes.
module tb_branch1_sequencer;

    localparam int BS = 8;
    localparam int AW = 3;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          i_start;
    logic [AW:0]   i_len;
    logic          i_pause;
    logic          o_busy;
    logic          o_done;
    logic          o_mem_en;
    logic [AW-1:0] o_mem_addr;
    logic          o_calc_valid;
    logic [AW-1:0] o_calc_addr;
    logic          i_calc_valid;
    logic          o_err;

    logic calc_p1, calc_p2, spur;
    int   total = 0;
    int   bad   = 0;

    branch1_sequencer #(.BRANCH_SIZE(BS), .MEM_LAT(1), .CALC_LAT(2)) dut (
        .aclk(aclk), .aresetn(aresetn), .i_start(i_start), .i_len(i_len),
        .i_pause(i_pause), .o_busy(o_busy), .o_done(o_done), .o_mem_en(o_mem_en),
        .o_mem_addr(o_mem_addr), .o_calc_valid(o_calc_valid), .o_calc_addr(o_calc_addr),
        .i_calc_valid(i_calc_valid), .o_err(o_err)
    );

    always #5 aclk = ~aclk;

    // Calc stage stand-in: valid delayed two cycles, shares the block reset.
    always @(posedge aclk) begin
        if (!aresetn) begin
            calc_p1 <= 1'b0;
            calc_p2 <= 1'b0;
        end else begin
            calc_p1 <= o_calc_valid;
            calc_p2 <= calc_p1;
        end
    end
    assign i_calc_valid = calc_p2 | spur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // One pass: expected timeline from the rules, then cycle-by-cycle comparison.
    // restart_at: -1 none, -2 at the DONE cycle, otherwise that cycle number.
    task automatic run_pass(input int len_in, input int pct, input logic [63:0] mask, input int restart_at);
        bit pz[64];
        bit em[64];
        int ea[64];
        int L, issued, k, last, done_c, rs;
        L = (len_in > BS) ? BS : len_in;
        for (int c = 0; c < 64; c++) begin
            pz[c] = mask[c] || (c > 0 && c < 40 && $urandom_range(99, 0) < pct);
            em[c] = 1'b0;
            ea[c] = 0;
        end
        issued = 0; k = 1; last = 0;
        while (issued < L) begin
            if (!pz[k]) begin
                em[k] = 1'b1;
                ea[k] = issued;
                issued++;
                last = k;
            end
            k++;
        end
        done_c = (L == 0) ? 1 : last + 1 + 2 + 1;
        rs = (restart_at == -2) ? done_c : restart_at;
        for (int c = 0; c <= done_c + 1; c++) begin
            @(negedge aclk);
            i_start = (c == 0) || (c == rs && c <= done_c);
            i_len   = (c == 0) ? 4'(len_in) : 4'($urandom_range(15, 1));
            i_pause = pz[c];
            #1;
            chk("mem_en", o_mem_en, em[c]);
            if (em[c]) chk("mem_addr", o_mem_addr, ea[c]);
            chk("calc_valid", o_calc_valid, (c > 0) ? em[c-1] : 1'b0);
            if (c > 0 && em[c-1]) chk("calc_addr", o_calc_addr, ea[c-1]);
            chk("busy", o_busy, (L > 0 && c >= 1 && c < done_c));
            chk("done", o_done, (c == done_c));
            if (c >= 1) chk("err", o_err, 0);
        end
        i_start = 1'b0;
        i_pause = 1'b0;
    endtask

    task automatic run_reset_mid();
        for (int c = 0; c <= 5; c++) begin
            @(negedge aclk);
            i_start = (c == 0);
            i_len   = 4'd8;
            i_pause = 1'b0;
            aresetn = (c != 5);
            #1;
            if (c >= 1 && c <= 4) begin
                chk("rst_pre_busy", o_busy, 1);
                chk("rst_pre_addr", o_mem_addr, c - 1);
            end
        end
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_mem_en", o_mem_en, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_calc_valid", o_calc_valid, 0);
        chk("rst_calc_addr", o_calc_addr, 0);
        chk("rst_err", o_err, 0);
        for (int c = 0; c < 12; c++) begin
            @(negedge aclk);
            #1;
            chk("post_rst_done", o_done, 0);
            chk("post_rst_busy", o_busy, 0);
            chk("post_rst_err", o_err, 0);
        end
    endtask

    task automatic spurious();
        @(negedge aclk);
        spur = 1'b1;
        #1;
        chk("spur_pre_err", o_err, 0);
        @(negedge aclk);
        spur = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("spur_err_held", o_err, 1);
            @(negedge aclk);
        end
    endtask

    initial begin
        int r;
        aresetn = 1'b0;
        i_start = 1'b0;
        i_len   = '0;
        i_pause = 1'b0;
        spur    = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_mem_en", o_mem_en, 0);
        chk("reset_mem_addr", o_mem_addr, 0);
        chk("reset_calc_valid", o_calc_valid, 0);
        chk("reset_calc_addr", o_calc_addr, 0);
        chk("reset_err", o_err, 0);
        @(negedge aclk);
        aresetn = 1'b1;

        run_pass(8, 0, 64'h0, -1);
        run_pass(5, 0, 64'h18, -1);
        run_pass(0, 0, 64'h0, -1);
        run_pass(12, 0, 64'h0, -1);
        run_pass(8, 0, 64'h0, 4);
        run_pass(6, 0, 64'h0, -2);
        run_pass(1, 0, 64'h0, -1);
        run_reset_mid();
        run_pass(8, 0, 64'h0, -1);
        spurious();
        run_pass(3, 30, 64'h0, -1);
        for (int n = 0; n < 10; n++) begin
            r = ($urandom_range(1, 0) == 1) ? -2 : int'($urandom_range(8, 2));
            run_pass(int'($urandom_range(12, 0)), int'($urandom_range(50, 0)), 64'h0, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
